// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC step and FSM encoding for the fetch stage.
package fetch_pkg;
    localparam int DEF_XLEN = 64;
    localparam int INS_W = 32;
    localparam int PC_STEP = 4;
    typedef enum logic {REQ = 1'b0, WAIT = 1'b1} state_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_if: instruction-memory, redirect and decode-side signals of the fetch stage.
interface fetch_if #(parameter int XLEN = fetch_pkg::DEF_XLEN);
    logic                       imem_req_valid;
    logic                       imem_req_ready;
    logic [XLEN-1:0]            imem_req_addr;
    logic                       imem_rsp_valid;
    logic [fetch_pkg::INS_W-1:0] imem_rsp_data;
    logic                       redirect_valid;
    logic [XLEN-1:0]            redirect_pc;
    logic                       dec_valid;
    logic                       dec_ready;
    logic [fetch_pkg::INS_W-1:0] dec_ins;
    logic [XLEN-1:0]            dec_pc;
    modport master(
        output imem_req_valid, imem_req_addr, dec_valid, dec_ins, dec_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
    );
    modport slave(
        input  imem_req_valid, imem_req_addr, dec_valid, dec_ins, dec_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH x W synchronous FIFO with flush; flush and active-low reset clear pointers.
module fetch_fifo #(
    parameter int W = 96,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [W-1:0]           din_i,
    output logic [W-1:0]           dout_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q;
    always_ff @(posedge clk) begin
        if (!reset || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push_i);
            rd_q  <= rd_q + AW'(pop_i);
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    always_ff @(posedge clk)
        if (push_i && reset && !flush_i) mem_q[wr_q] <= din_i;
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner and single-outstanding fetch FSM feeding decode through fetch_fifo.
// Define FETCH_PERF_EN to add the perf_fetched/perf_dropped saturating counters.
module fetch_queue import fetch_pkg::*; #(
    parameter int              XLEN = DEF_XLEN,
    parameter int              DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic  clk,
    input  logic  reset,
    fetch_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic [CW-1:0]   count;
    logic            empty, full, inflight, accept, rsp, push, pop, stay;
    assign inflight = state_q == WAIT;
    assign bus.imem_req_valid = reset && !inflight && (count + CW'(inflight) < CW'(DEPTH));
    assign bus.imem_req_addr  = pc_q;
    assign accept = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp    = inflight && bus.imem_rsp_valid;
    assign push   = rsp && !drop_q && !bus.redirect_valid && !full;
    assign pop    = !empty && bus.dec_ready && !bus.redirect_valid;
    // A response arriving with the redirect retires the old request, so nothing stays stale.
    assign stay   = (inflight && !bus.imem_rsp_valid) || accept;
    always_comb begin
        pc_d    = bus.redirect_valid ? (bus.redirect_pc & ~XLEN'(3)) : accept ? pc_q + XLEN'(PC_STEP) : pc_q;
        state_d = bus.redirect_valid ? (stay ? WAIT : REQ) : accept ? WAIT : rsp ? REQ : state_q;
        drop_d  = bus.redirect_valid ? stay : rsp ? 1'b0 : drop_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end
    // pc_q has already advanced past the outstanding request.
    fetch_fifo #(.W(XLEN + INS_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push_i(push),
        .pop_i(pop),
        .flush_i(bus.redirect_valid),
        .din_i({pc_q - XLEN'(PC_STEP), bus.imem_rsp_data}),
        .dout_o({bus.dec_pc, bus.dec_ins}),
        .count_o(count),
        .empty_o(empty),
        .full_o(full)
    );
    assign bus.dec_valid = !empty;
`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, dropped_q;
    logic [32:0] fetched_d, dropped_d;
    assign fetched_d = {1'b0, fetched_q} + 33'(push);
    assign dropped_d = {1'b0, dropped_q} + 33'(rsp && (drop_q || bus.redirect_valid))
                     + (bus.redirect_valid ? 33'(count) : 33'd0);
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetched_q <= '0;
            dropped_q <= '0;
        end else begin
            fetched_q <= fetched_d[32] ? '1 : fetched_d[31:0];
            dropped_q <= dropped_d[32] ? '1 : dropped_d[31:0];
        end
    end
    assign perf_fetched = fetched_q;
    assign perf_dropped = dropped_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table, directed and random checks of fetch_queue against a queue-based model.
module tb_fetch_queue;
    localparam int XLEN = 64;
    localparam int DEPTH = 4;
    logic clk = 0;
    logic reset = 0;
    always #5 clk = ~clk;
    fetch_if #(.XLEN(XLEN)) bus();
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_dropped;
`endif
    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_dropped(perf_dropped)
`endif
    );
    int total = 0;
    int bad = 0;
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask
    typedef struct { logic [63:0] pc; logic [31:0] ins; } ent_t;
    ent_t q[$];
    logic [63:0] m_pc, m_addr;
    bit m_wait, m_drop;
    int m_fet, m_drp;
    bit auto_mem = 0;
    bit mem_pend = 0;
    int mem_dly = 0;
    int dly_max = 0;
    int hs = 0;
    task automatic tick();
        bit s_rst, s_rdy, s_rv, s_red, s_dr, acc, rsp_ev, stay, dacc, exp_rv;
        logic [31:0] s_d;
        logic [63:0] s_rpc;
        if (auto_mem) begin
            bus.imem_rsp_valid = mem_pend && mem_dly == 0;
            bus.imem_rsp_data = $urandom;
        end
        #1;
        s_rst = reset; s_rdy = bus.imem_req_ready; s_rv = bus.imem_rsp_valid; s_d = bus.imem_rsp_data;
        s_red = bus.redirect_valid; s_rpc = bus.redirect_pc; s_dr = bus.dec_ready;
        dacc = bus.imem_req_valid && bus.imem_req_ready;
        if (dacc) hs++;
        @(posedge clk);
        if (!s_rst) begin
            q.delete(); m_pc = 0; m_wait = 0; m_drop = 0; m_fet = 0; m_drp = 0;
        end else begin
            acc = !m_wait && q.size() < DEPTH && s_rdy;
            rsp_ev = m_wait && s_rv;
            if (s_red) begin
                m_drp += q.size() + (rsp_ev ? 1 : 0);
                q.delete();
                m_pc = s_rpc & ~64'h3;
                stay = (m_wait && !rsp_ev) || acc;
                m_wait = stay;
                m_drop = stay;
            end else begin
                if (q.size() > 0 && s_dr) void'(q.pop_front());
                if (rsp_ev) begin
                    if (m_drop) m_drp++;
                    else begin
                        q.push_back('{pc: m_addr, ins: s_d});
                        m_fet++;
                    end
                    m_wait = 0;
                    m_drop = 0;
                end
                if (acc) begin
                    m_addr = m_pc;
                    m_pc += 4;
                    m_wait = 1;
                end
            end
        end
        if (!s_rst) mem_pend = 0;
        else if (mem_pend && mem_dly == 0 && s_rv) mem_pend = 0;
        else if (mem_pend) mem_dly--;
        if (s_rst && dacc) begin
            mem_pend = 1;
            mem_dly = $urandom_range(dly_max, 0);
        end
        #1;
        chk("m_dec_valid", bus.dec_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("m_dec_pc", bus.dec_pc, q[0].pc);
            chk("m_dec_ins", bus.dec_ins, q[0].ins);
        end
        exp_rv = reset && !m_wait && q.size() < DEPTH;
        chk("m_req_valid", bus.imem_req_valid, exp_rv);
        if (exp_rv) chk("m_req_addr", bus.imem_req_addr, m_pc);
`ifdef FETCH_PERF_EN
        chk("m_perf_fetched", perf_fetched, m_fet);
        chk("m_perf_dropped", perf_dropped, m_drp);
`endif
    endtask
    task automatic do_reset();
        reset = 0;
        bus.imem_rsp_valid = 0;
        bus.redirect_valid = 0;
        tick();
        reset = 1;
    endtask
    task automatic fetch1();
        bus.imem_req_ready = 1;
        tick();
        bus.imem_rsp_valid = 1;
        bus.imem_rsp_data = $urandom;
        tick();
        bus.imem_rsp_valid = 0;
    endtask
    typedef struct {
        bit rst, rdy, rv, dr;
        logic [31:0] d;
        bit dv;
        logic [63:0] dpc;
        logic [31:0] dins;
        bit qv;
        logic [63:0] qa;
    } vec_t;
    vec_t tbl[10];
    initial begin
        tbl[0] = '{0, 1, 0, 1, 32'h0,        0, 64'h0,  32'h0,        0, 64'h0};
        tbl[1] = '{0, 1, 0, 1, 32'h0,        0, 64'h0,  32'h0,        0, 64'h0};
        tbl[2] = '{1, 1, 0, 1, 32'h0,        0, 64'h0,  32'h0,        0, 64'h0};
        tbl[3] = '{1, 1, 1, 1, 32'h00000013, 1, 64'h0,  32'h00000013, 1, 64'h4};
        tbl[4] = '{1, 1, 0, 1, 32'h0,        0, 64'h0,  32'h0,        0, 64'h0};
        tbl[5] = '{1, 1, 1, 1, 32'h00100093, 1, 64'h4,  32'h00100093, 1, 64'h8};
        tbl[6] = '{1, 1, 0, 1, 32'h0,        0, 64'h0,  32'h0,        0, 64'h0};
        tbl[7] = '{1, 1, 1, 1, 32'h00200113, 1, 64'h8,  32'h00200113, 1, 64'hc};
        tbl[8] = '{1, 1, 0, 1, 32'h0,        0, 64'h0,  32'h0,        0, 64'h0};
        tbl[9] = '{1, 1, 1, 1, 32'h00300193, 1, 64'hc,  32'h00300193, 1, 64'h10};
        bus.imem_req_ready = 0;
        bus.imem_rsp_valid = 0;
        bus.imem_rsp_data = 0;
        bus.redirect_valid = 0;
        bus.redirect_pc = 0;
        bus.dec_ready = 0;
        for (int i = 0; i < 10; i++) begin
            reset = tbl[i].rst;
            bus.imem_req_ready = tbl[i].rdy;
            bus.imem_rsp_valid = tbl[i].rv;
            bus.imem_rsp_data = tbl[i].d;
            bus.dec_ready = tbl[i].dr;
            tick();
            chk("t1_dec_valid", bus.dec_valid, tbl[i].dv);
            if (tbl[i].dv) begin
                chk("t1_dec_pc", bus.dec_pc, tbl[i].dpc);
                chk("t1_dec_ins", bus.dec_ins, tbl[i].dins);
            end
            chk("t1_req_valid", bus.imem_req_valid, tbl[i].qv);
            if (tbl[i].qv) chk("t1_req_addr", bus.imem_req_addr, tbl[i].qa);
        end
        bus.imem_rsp_valid = 0;
        do_reset();
        bus.dec_ready = 0;
        bus.imem_req_ready = 1;
        auto_mem = 1;
        dly_max = 0;
        hs = 0;
        repeat (20) tick();
        chk("t2_requests", hs, 4);
        chk("t2_req_valid", bus.imem_req_valid, 0);
        chk("t2_dec_valid", bus.dec_valid, 1);
        bus.dec_ready = 1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_drain_pc", bus.dec_pc, 64'(4 * k));
            tick();
        end
        auto_mem = 0;
        do_reset();
        bus.dec_ready = 0;
        fetch1();
        fetch1();
        chk("t3_req_addr", bus.imem_req_addr, 64'h8);
        tick();
        bus.redirect_valid = 1;
        bus.redirect_pc = 64'h100;
        tick();
        bus.redirect_valid = 0;
        chk("t3_dec_valid_flush", bus.dec_valid, 0);
        bus.imem_rsp_valid = 1;
        bus.imem_rsp_data = 32'hdead0008;
        tick();
        bus.imem_rsp_valid = 0;
        chk("t3_dec_valid_drop", bus.dec_valid, 0);
        chk("t3_req_addr_new", bus.imem_req_addr, 64'h100);
        fetch1();
        chk("t3_dec_pc", bus.dec_pc, 64'h100);
        do_reset();
        bus.dec_ready = 0;
        fetch1();
        fetch1();
        bus.dec_ready = 1;
        bus.redirect_valid = 1;
        bus.redirect_pc = 64'h203;
        tick();
        bus.redirect_valid = 0;
        chk("t4_dec_valid", bus.dec_valid, 0);
        chk("t4_req_valid_wait", bus.imem_req_valid, 0);
        bus.imem_rsp_valid = 1;
        tick();
        bus.imem_rsp_valid = 0;
        chk("t4_dec_valid_drop", bus.dec_valid, 0);
        chk("t4_req_valid", bus.imem_req_valid, 1);
        chk("t4_req_addr", bus.imem_req_addr, 64'h200);
        do_reset();
        bus.dec_ready = 0;
        fetch1();
        fetch1();
        tick();
        reset = 0;
        tick();
        chk("t5_dec_valid_rst", bus.dec_valid, 0);
        chk("t5_req_valid_rst", bus.imem_req_valid, 0);
        reset = 1;
        bus.imem_req_ready = 0;
        bus.imem_rsp_valid = 1;
        tick();
        bus.imem_rsp_valid = 0;
        chk("t5_dec_valid_late", bus.dec_valid, 0);
        chk("t5_req_valid", bus.imem_req_valid, 1);
        chk("t5_req_addr", bus.imem_req_addr, 64'h0);
`ifdef FETCH_PERF_EN
        do_reset();
        bus.dec_ready = 1;
        repeat (7) fetch1();
        bus.imem_req_ready = 0;
        tick();
        bus.dec_ready = 0;
        repeat (3) fetch1();
        tick();
        bus.redirect_valid = 1;
        bus.redirect_pc = 64'h40;
        tick();
        bus.redirect_valid = 0;
        bus.imem_rsp_valid = 1;
        tick();
        bus.imem_rsp_valid = 0;
        chk("t6_perf_fetched", perf_fetched, 10);
        chk("t6_perf_dropped", perf_dropped, 4);
`endif
        do_reset();
        auto_mem = 1;
        dly_max = 3;
        for (int c = 0; c < 3000; c++) begin
            reset = $urandom_range(99, 0) != 0;
            bus.imem_req_ready = $urandom_range(1, 0) == 1;
            bus.dec_ready = $urandom_range(3, 0) != 0;
            bus.redirect_valid = $urandom_range(19, 0) == 0;
            bus.redirect_pc = {$urandom, $urandom};
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
